// File: rtl/and_block_assign_amisha.sv
// Three-input AND with a combinational result, a registered copy, edge pulses
// and a saturating count of cycles in which the AND was sampled high.
module and_block_assign_amisha #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_amisha,
  input  logic             rst_n_amisha,
  input  logic             a_amisha,
  input  logic             b_amisha,
  input  logic             c_amisha,
  input  logic             clr_amisha,
  output logic             y_amisha,
  output logic             y_q_amisha,
  output logic             y_rise_amisha,
  output logic             y_fall_amisha,
  output logic [CNT_W-1:0] high_cnt_amisha
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Plain & so X/Z on an operand propagates unless another operand is 0.
  assign y_amisha = a_amisha & b_amisha & c_amisha;

  // Observation registers: reset beats clear, clear beats count.
  always_ff @(posedge clk_amisha) begin
    if (!rst_n_amisha) begin
      y_q_amisha      <= 1'b0;
      y_rise_amisha   <= 1'b0;
      y_fall_amisha   <= 1'b0;
      high_cnt_amisha <= '0;
    end else begin
      y_q_amisha    <= y_amisha;
      y_rise_amisha <= y_amisha & ~y_q_amisha;
      y_fall_amisha <= ~y_amisha & y_q_amisha;
      if (clr_amisha) begin
        high_cnt_amisha <= '0;
      end else if (y_amisha && (high_cnt_amisha != CNT_MAX)) begin
        high_cnt_amisha <= high_cnt_amisha + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_and_block_assign_amisha.sv
// Scoreboard bench for and_block_assign_amisha: a default-width instance and
// a CNT_W=3 instance share stimulus so saturation is reachable quickly.
module tb_and_block_assign_amisha;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst_n, a, b, c, clr;
  logic        y, y_q, y_rise, y_fall;
  logic [15:0] cnt;
  logic        y3, y_q3, y_rise3, y_fall3;
  logic [2:0]  cnt3;

  typedef struct packed {
    logic        yq;
    logic        rise;
    logic        fall;
    logic [15:0] cnt;
    logic [2:0]  cnt3;
  } obs_t;

  obs_t exp_q[$];
  obs_t m;
  int   n_checks = 0;
  int   n_fail   = 0;

  and_block_assign_amisha dut (
    .clk_amisha(clk), .rst_n_amisha(rst_n), .a_amisha(a), .b_amisha(b),
    .c_amisha(c), .clr_amisha(clr), .y_amisha(y), .y_q_amisha(y_q),
    .y_rise_amisha(y_rise), .y_fall_amisha(y_fall), .high_cnt_amisha(cnt)
  );

  and_block_assign_amisha #(.CNT_W(3)) dut3 (
    .clk_amisha(clk), .rst_n_amisha(rst_n), .a_amisha(a), .b_amisha(b),
    .c_amisha(c), .clr_amisha(clr), .y_amisha(y3), .y_q_amisha(y_q3),
    .y_rise_amisha(y_rise3), .y_fall_amisha(y_fall3), .high_cnt_amisha(cnt3)
  );

  always #5 if (clk_en) clk = ~clk;

  // Drive one edge's inputs, push the expected post-edge state, then wait
  // until just after that edge.
  task automatic drive_edge(input logic ia, ib, ic, iclr, irst_n);
    logic yy;
    a = ia; b = ib; c = ic; clr = iclr; rst_n = irst_n;
    yy = ia & ib & ic;
    if (!irst_n) begin
      m = '0;
    end else begin
      m.rise = yy & ~m.yq;
      m.fall = ~yy & m.yq;
      m.yq   = yy;
      if (iclr) begin
        m.cnt  = '0;
        m.cnt3 = '0;
      end else if (yy) begin
        if (m.cnt != 16'hFFFF) m.cnt = m.cnt + 16'd1;
        if (m.cnt3 != 3'd7) m.cnt3 = m.cnt3 + 3'd1;
      end
    end
    exp_q.push_back(m);
    @(posedge clk);
    #1;
  endtask

  task automatic test_comb_sweep();
    logic [2:0] pat [8];
    logic       ey  [8];
    pat = '{3'b000, 3'b101, 3'b111, 3'b001, 3'b011, 3'b010, 3'b100, 3'b110};
    ey  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      {a, b, c} = pat[i];
      rst_n = i[0];
      #100;
      n_checks++;
      if (y !== ey[i] || y3 !== ey[i]) begin
        n_fail++;
        $display("FAIL comb_sweep abc=%b: got y=%b y3=%b, expected %b", pat[i], y, y3, ey[i]);
      end
    end
  endtask

  task automatic test_reset();
    obs_t e, o;
    clk_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive_edge(1, 1, 1, 0, 0);
      e = exp_q.pop_front();
      o = '{y_q, y_rise, y_fall, cnt, cnt3};
      n_checks++;
      if (o !== e || y !== 1'b1) begin
        n_fail++;
        $display("FAIL reset edge %0d: got %h y=%b, expected %h y=1", i, o, y, e);
      end
    end
  endtask

  task automatic test_edge_pulses();
    obs_t e, o;
    logic [3:0] abc [5];
    abc = '{4'b1110, 4'b1110, 4'b1110, 4'b0110, 4'b0110};
    for (int i = 0; i < 5; i++) begin
      drive_edge(abc[i][3], abc[i][2], abc[i][1], 0, 1);
      e = exp_q.pop_front();
      o = '{y_q, y_rise, y_fall, cnt, cnt3};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL edge_pulses step %0d: got %h, expected %h", i, o, e);
      end
    end
    n_checks++;
    if (cnt !== 16'd3 || y_fall !== 1'b0) begin
      n_fail++;
      $display("FAIL edge_pulses final: got cnt=%0d fall=%b, expected cnt=3 fall=0", cnt, y_fall);
    end
  endtask

  task automatic test_clear();
    obs_t e, o;
    drive_edge(1, 1, 1, 1, 1);
    e = exp_q.pop_front();
    o = '{y_q, y_rise, y_fall, cnt, cnt3};
    n_checks++;
    if (o !== e || cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL clear_priority: got %h cnt=%0d, expected %h cnt=0", o, cnt, e);
    end
    drive_edge(1, 1, 1, 0, 1);
    e = exp_q.pop_front();
    o = '{y_q, y_rise, y_fall, cnt, cnt3};
    n_checks++;
    if (o !== e || cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL clear_resume: got %h cnt=%0d, expected %h cnt=1", o, cnt, e);
    end
  endtask

  task automatic test_saturation();
    obs_t e, o;
    for (int i = 0; i < 10; i++) begin
      drive_edge(1, 1, 1, 0, 1);
      e = exp_q.pop_front();
      o = '{y_q, y_rise, y_fall, cnt, cnt3};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL saturation step %0d: got %h, expected %h", i, o, e);
      end
    end
    n_checks++;
    if (cnt3 !== 3'd7 || cnt !== 16'd11) begin
      n_fail++;
      $display("FAIL saturation final: got cnt3=%0d cnt=%0d, expected 7 and 11", cnt3, cnt);
    end
  endtask

  task automatic test_reset_mid();
    obs_t e, o;
    drive_edge(1, 1, 1, 1, 1);
    void'(exp_q.pop_front());
    for (int i = 0; i < 5; i++) begin
      drive_edge(1, 1, 1, 0, 1);
      void'(exp_q.pop_front());
    end
    n_checks++;
    if (cnt !== 16'd5 || cnt3 !== 3'd5) begin
      n_fail++;
      $display("FAIL reset_mid precount: got cnt=%0d cnt3=%0d, expected 5", cnt, cnt3);
    end
    drive_edge(1, 1, 1, 0, 0);
    e = exp_q.pop_front();
    o = '{y_q, y_rise, y_fall, cnt, cnt3};
    n_checks++;
    if (o !== e || o !== '0 || y !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: got %h y=%b, expected %h y=1", o, y, e);
    end
    drive_edge(1, 1, 1, 0, 1);
    e = exp_q.pop_front();
    o = '{y_q, y_rise, y_fall, cnt, cnt3};
    n_checks++;
    if (o !== e || y_rise !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_rise: got %h rise=%b, expected %h rise=1", o, y_rise, e);
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, o;
    logic ia, ib, ic;
    for (int i = 0; i < 60; i++) begin
      ia = ($urandom_range(0, 3) != 0);
      ib = ($urandom_range(0, 3) != 0);
      ic = ($urandom_range(0, 3) != 0);
      drive_edge(ia, ib, ic, ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) != 0));
      e = exp_q.pop_front();
      o = '{y_q, y_rise, y_fall, cnt, cnt3};
      n_checks++;
      if (o !== e || y !== (ia & ib & ic)) begin
        n_fail++;
        $display("FAIL back_to_back %0d: got %h y=%b, expected %h y=%b", i, o, y, e, ia & ib & ic);
      end
    end
  endtask

  initial begin
    m = '0;
    rst_n = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0; clr = 1'b0;
    test_comb_sweep();
    test_reset();
    test_edge_pulses();
    test_clear();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
